// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock fifo and its read-side consumers.
//   FIFO_DEPTH / PTR_WIDTH : fifo geometry constants.
//   SKID_DEPTH             : entries in the stream output skid buffer.
//   pkt_state_t            : packetizer framing states.
//   has_slot()             : checks whether another beat may be committed to the skid buffer.
package fifo_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DRAIN
    } pkt_state_t;

    // A new beat fits if the entries already buffered, plus the ones
    // still on their way, minus the one leaving this cycle, leave a free slot.
    function automatic logic has_slot(input logic [1:0] occ,
                                      input logic       inflight,
                                      input logic       xfer);
        return ({1'b0, occ} + {2'b00, inflight} - {2'b00, xfer}) < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry {data, last} stream buffer.
//   clk, reset           : clock, synchronous active-high reset
//   push, push_data/last : write one beat (caller guarantees space)
//   pop                  : remove the head beat (caller guarantees occupancy != 0)
//   head_data/last       : oldest beat; held stable until popped
//   occupancy            : beats held (0..2)
module axis_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic [1:0]            occupancy
);

    // Entries stored as {last, data}; ent0 is always the head.
    logic [DATA_WIDTH:0] ent0, ent1;
    logic [1:0]          wr_idx;

    // A simultaneous pop shifts ent1 down, so the write slot moves with it.
    assign wr_idx = occupancy - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= 2'd0;
            ent0      <= '0;
            ent1      <= '0;
        end else begin
            occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
            if (pop)
                ent0 <= ent1;
            if (push) begin
                if (wr_idx == 2'd0)
                    ent0 <= {push_last, push_data};
                else
                    ent1 <= {push_last, push_data};
            end
        end
    end

    assign head_data = ent0[DATA_WIDTH-1:0];
    assign head_last = ent0[DATA_WIDTH];

endmodule

// File: rtl/fifo_rd_packetizer.sv
// Pops words from the fifo read port and frames them as AXI-Stream packets:
// one header beat (zero-extended sequence number) then PKT_LEN payload beats.
//   aclk, areset        : read-domain clock, synchronous active-high reset
//   fifo_empty          : fifo empty flag
//   fifo_rd_en          : fifo pop request
//   fifo_rd_data        : pop data, valid the cycle after fifo_rd_en
//   fifo_uflow          : fifo underflow pulse
//   m_tdata/tvalid/tready/tlast : stream master
//   pkt_count           : completed packets (wraps at 2^16)
//   uflow_err           : sticky underflow flag
module fifo_rd_packetizer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16,
    parameter int SEQ_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_uflow,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [15:0]           pkt_count,
    output logic                  uflow_err
);

    localparam int                BEAT_W   = $clog2(PKT_LEN + 1);
    localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(PKT_LEN - 1);
    localparam logic [BEAT_W-1:0] FULL_CNT = BEAT_W'(PKT_LEN);

    pkt_state_t            state, state_nxt;
    logic [SEQ_WIDTH-1:0]  seq;
    logic [BEAT_W-1:0]     beats_issued;
    logic                  rd_pending;   // a pop was issued last cycle
    logic                  pend_last;    // ...and it is the final payload word
    logic [1:0]            occ;
    logic                  xfer, hdr_push, rd_issue, tlast_done;
    logic                  push, push_last;
    logic [DATA_WIDTH-1:0] push_data;

    assign m_tvalid   = (occ != 2'd0);
    assign xfer       = m_tvalid && m_tready;
    assign fifo_rd_en = rd_issue;

    always_comb begin
        state_nxt  = state;
        hdr_push   = 1'b0;
        rd_issue   = 1'b0;
        tlast_done = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && has_slot(occ, 1'b0, xfer)) begin
                    hdr_push  = 1'b1;
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!fifo_empty && beats_issued < FULL_CNT &&
                    has_slot(occ, rd_pending, xfer)) begin
                    rd_issue = 1'b1;
                    if (beats_issued == LAST_IDX)
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && m_tlast) begin
                    tlast_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // State may still read PAYLOAD during the reset cycle; never pop then.
        if (areset)
            rd_issue = 1'b0;
    end

    // Headers only go in from IDLE, where no read is outstanding, so the
    // two push sources never collide.
    assign push      = hdr_push | rd_pending;
    assign push_data = rd_pending ? fifo_rd_data : DATA_WIDTH'(seq);
    assign push_last = rd_pending & pend_last;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state        <= IDLE;
            seq          <= '0;
            beats_issued <= '0;
            rd_pending   <= 1'b0;
            pend_last    <= 1'b0;
            pkt_count    <= 16'd0;
            uflow_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_pending <= rd_issue;
            if (hdr_push)
                beats_issued <= '0;
            if (rd_issue) begin
                beats_issued <= beats_issued + BEAT_W'(1);
                pend_last    <= (beats_issued == LAST_IDX);
            end
            if (tlast_done) begin
                seq       <= seq + SEQ_WIDTH'(1);
                pkt_count <= pkt_count + 16'd1;
            end
            if (fifo_uflow)
                uflow_err <= 1'b1;
        end
    end

    axis_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (aclk),
        .reset     (areset),
        .push      (push),
        .push_data (push_data),
        .push_last (push_last),
        .pop       (xfer),
        .head_data (m_tdata),
        .head_last (m_tlast),
        .occupancy (occ)
    );

endmodule

// File: tb/tb_fifo_rd_packetizer.sv
// Self-checking bench for fifo_rd_packetizer (DATA_WIDTH=8, PKT_LEN=16).
// A queue stands in for the fifo; the expected stream is built from the
// packet rules: header = packet number mod 256, then 16 words in push order.
module tb_fifo_rd_packetizer;

    localparam int DW = 8;
    localparam int PL = 16;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_uflow = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [15:0]   pkt_count;
    logic          uflow_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] fq[$];       // words currently in the modelled fifo
    logic [7:0] words[$];    // every word pushed since the last reset
    logic [8:0] got[$];      // transferred beats {last, data}
    int         got_cyc[$];
    logic [8:0] exp[$];
    int         ready_mode = 3;  // 0: ready=1, 1: 1,0,0,1 pattern, 2: random, 3: ready=0
    logic       rd_req = 1'b0;
    int         rd_empty_viol = 0;
    int         stall_viol = 0;
    logic       stalled_prev = 1'b0;
    logic [8:0] prev_beat = '0;

    always #5 aclk = ~aclk;

    fifo_rd_packetizer #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PL),
        .SEQ_WIDTH  (8)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_uflow   (fifo_uflow),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .pkt_count    (pkt_count),
        .uflow_err    (uflow_err)
    );

    always @(posedge aclk) cyc++;

    // Stream and read-port monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        rd_req = fifo_rd_en && !areset;
        if (areset) begin
            stalled_prev = 1'b0;
        end else begin
            if (fifo_rd_en && fifo_empty) rd_empty_viol++;
            if (stalled_prev && (!m_tvalid || {m_tlast, m_tdata} !== prev_beat)) stall_viol++;
            if (m_tvalid && m_tready) begin
                got.push_back({m_tlast, m_tdata});
                got_cyc.push_back(cyc);
            end
            stalled_prev = m_tvalid && !m_tready;
            prev_beat    = {m_tlast, m_tdata};
        end
    end

    // Fifo read port and sink ready, updated just after each edge.
    always @(posedge aclk) begin
        #1;
        if (rd_req && fq.size() > 0) fifo_rd_data = fq.pop_front();
        else                         fifo_rd_data = 8'($urandom);
        fifo_empty = (fq.size() == 0);
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fq.push_back(w);
        words.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick(3);
        fq.delete();
        words.delete();
        got.delete();
        got_cyc.delete();
        fifo_empty    = 1'b1;
        rd_empty_viol = 0;
        stall_viol    = 0;
        areset        = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && got.size() < n; i++) tick();
        tick(2);
    endtask

    // Reference stream for npkt packets after reset, from the pushed words.
    task automatic build_exp(input int npkt);
        exp.delete();
        for (int p = 0; p < npkt; p++) begin
            exp.push_back({1'b0, 8'(p % 256)});
            for (int i = 0; i < PL; i++)
                exp.push_back({(i == PL - 1), words[p * PL + i]});
        end
    endtask

    task automatic test_reset();
        ready_mode = 3;
        areset = 1'b1;
        tick(3);
        n_vec++; if (m_tvalid !== 1'b0)   begin n_err++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
        n_vec++; if (m_tlast !== 1'b0)    begin n_err++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
        n_vec++; if (m_tdata !== 8'h00)   begin n_err++; $display("FAIL rst_tdata: got %h want 00", m_tdata); end
        n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
        n_vec++; if (pkt_count !== 16'd0) begin n_err++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
        n_vec++; if (uflow_err !== 1'b0)  begin n_err++; $display("FAIL rst_uflow_err: got %b want 0", uflow_err); end
        areset = 1'b0;
        tick(3);
        n_vec++; if (m_tvalid !== 1'b0)   begin n_err++; $display("FAIL idle_tvalid: got %b want 0", m_tvalid); end
        n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL idle_rd_en: got %b want 0", fifo_rd_en); end
    endtask

    task automatic test_basic();
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < PL; i++) push_word(8'(i));
        wait_beats(PL + 1, 80);
        build_exp(1);
        n_vec++;
        if (got.size() != exp.size()) begin
            n_err++; $display("FAIL basic_count: got %0d beats want %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_vec++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_err++;
                $display("FAIL basic_beat%0d: got %h want %h", i, (i < got.size()) ? got[i] : 9'h1ff, exp[i]);
            end
        end
        // Payload streams one beat per cycle once the first word lands.
        if (got_cyc.size() >= PL + 1) begin
            n_vec++;
            if (got_cyc[PL] - got_cyc[1] != PL - 1) begin
                n_err++; $display("FAIL basic_rate: got span %0d want %0d", got_cyc[PL] - got_cyc[1], PL - 1);
            end
        end
        n_vec++; if (pkt_count !== 16'd1) begin n_err++; $display("FAIL basic_pkt_count: got %0d want 1", pkt_count); end
    endtask

    task automatic test_back_to_back();
        int mis;
        int nlast;
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < 3 * PL; i++) push_word(8'($urandom));
        wait_beats(3 * (PL + 1), 200);
        build_exp(3);
        mis = 0;
        nlast = 0;
        for (int i = 0; i < exp.size(); i++)
            if (i >= got.size() || got[i] !== exp[i]) mis++;
        foreach (got[i]) if (got[i][8]) nlast++;
        n_vec++;
        if (mis != 0 || got.size() != exp.size()) begin
            n_err++; $display("FAIL b2b_stream: %0d beats differ, got %0d beats want %0d", mis, got.size(), exp.size());
        end
        for (int p = 0; p < 3; p++) begin
            n_vec++;
            if (got.size() <= p * (PL + 1) || got[p * (PL + 1)] !== {1'b0, 8'(p)}) begin
                n_err++; $display("FAIL b2b_header%0d: got %h want %h", p,
                                  (got.size() > p * (PL + 1)) ? got[p * (PL + 1)] : 9'h1ff, {1'b0, 8'(p)});
            end
        end
        n_vec++; if (nlast != 3) begin n_err++; $display("FAIL b2b_tlast_count: got %0d want 3", nlast); end
        n_vec++; if (pkt_count !== 16'd3) begin n_err++; $display("FAIL b2b_pkt_count: got %0d want 3", pkt_count); end
    endtask

    task automatic test_backpressure();
        int mis;
        do_reset();
        ready_mode = 1;
        for (int i = 0; i < 2 * PL; i++) push_word(8'($urandom));
        wait_beats(2 * (PL + 1), 400);
        ready_mode = 2;
        for (int i = 0; i < 2 * PL; i++) push_word(8'($urandom));
        wait_beats(4 * (PL + 1), 600);
        ready_mode = 0;
        tick(4);
        build_exp(4);
        mis = 0;
        for (int i = 0; i < exp.size(); i++)
            if (i >= got.size() || got[i] !== exp[i]) mis++;
        n_vec++;
        if (mis != 0 || got.size() != exp.size()) begin
            n_err++; $display("FAIL bp_stream: %0d beats differ, got %0d beats want %0d", mis, got.size(), exp.size());
        end
        n_vec++; if (stall_viol != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol); end
        n_vec++; if (pkt_count !== 16'd4) begin n_err++; $display("FAIL bp_pkt_count: got %0d want 4", pkt_count); end
    endtask

    task automatic test_starvation();
        int mis;
        int gap_valid;
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < 5; i++) push_word(8'(8'hA0 + i));
        wait_beats(6, 40);
        gap_valid = 0;
        repeat (20) begin
            @(negedge aclk);
            if (m_tvalid) gap_valid++;
        end
        @(posedge aclk); #1;
        for (int i = 0; i < 11; i++) push_word(8'(8'hB0 + i));
        wait_beats(PL + 1, 60);
        build_exp(1);
        mis = 0;
        for (int i = 0; i < exp.size(); i++)
            if (i >= got.size() || got[i] !== exp[i]) mis++;
        n_vec++; if (gap_valid != 0) begin n_err++; $display("FAIL starve_gap_valid: got %0d valid cycles want 0", gap_valid); end
        n_vec++;
        if (mis != 0 || got.size() != exp.size()) begin
            n_err++; $display("FAIL starve_stream: %0d beats differ, got %0d beats want %0d", mis, got.size(), exp.size());
        end
        n_vec++; if (rd_empty_viol != 0) begin n_err++; $display("FAIL starve_rd_empty: got %0d reads while empty want 0", rd_empty_viol); end
        n_vec++; if (pkt_count !== 16'd1) begin n_err++; $display("FAIL starve_pkt_count: got %0d want 1", pkt_count); end
    endtask

    task automatic test_uflow_reset();
        int mis;
        int nlast;
        do_reset();
        ready_mode = 0;
        fifo_uflow = 1'b1;
        tick();
        fifo_uflow = 1'b0;
        tick();
        n_vec++; if (uflow_err !== 1'b1) begin n_err++; $display("FAIL uflow_set: got %b want 1", uflow_err); end
        tick(10);
        n_vec++; if (uflow_err !== 1'b1) begin n_err++; $display("FAIL uflow_sticky: got %b want 1", uflow_err); end
        for (int i = 0; i < PL; i++) push_word(8'($urandom));
        wait_beats(8, 40);
        nlast = 0;
        foreach (got[i]) if (got[i][8]) nlast++;
        areset = 1'b1;
        tick(2);
        n_vec++; if (nlast != 0)          begin n_err++; $display("FAIL mid_no_tlast: got %0d tlast beats want 0", nlast); end
        n_vec++; if (m_tvalid !== 1'b0)   begin n_err++; $display("FAIL mid_rst_tvalid: got %b want 0", m_tvalid); end
        n_vec++; if (m_tlast !== 1'b0)    begin n_err++; $display("FAIL mid_rst_tlast: got %b want 0", m_tlast); end
        n_vec++; if (m_tdata !== 8'h00)   begin n_err++; $display("FAIL mid_rst_tdata: got %h want 00", m_tdata); end
        n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_rd_en: got %b want 0", fifo_rd_en); end
        n_vec++; if (pkt_count !== 16'd0) begin n_err++; $display("FAIL mid_rst_pkt_count: got %0d want 0", pkt_count); end
        n_vec++; if (uflow_err !== 1'b0)  begin n_err++; $display("FAIL mid_rst_uflow_err: got %b want 0", uflow_err); end
        do_reset();
        for (int i = 0; i < PL; i++) push_word(8'($urandom));
        wait_beats(PL + 1, 80);
        build_exp(1);
        mis = 0;
        for (int i = 0; i < exp.size(); i++)
            if (i >= got.size() || got[i] !== exp[i]) mis++;
        n_vec++;
        if (got.size() == 0 || got[0] !== 9'h000) begin
            n_err++; $display("FAIL post_rst_header: got %h want 000", (got.size() > 0) ? got[0] : 9'h1ff);
        end
        n_vec++;
        if (mis != 0 || got.size() != exp.size()) begin
            n_err++; $display("FAIL post_rst_stream: %0d beats differ, got %0d beats want %0d", mis, got.size(), exp.size());
        end
    endtask

    task automatic test_seq_wrap();
        int mis;
        int npkt;
        npkt = 257;
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < npkt * PL; i++) push_word(8'($urandom));
        wait_beats(npkt * (PL + 1), npkt * 20);
        build_exp(npkt);
        mis = 0;
        for (int i = 0; i < exp.size(); i++)
            if (i >= got.size() || got[i] !== exp[i]) mis++;
        n_vec++;
        if (mis != 0 || got.size() != exp.size()) begin
            n_err++; $display("FAIL wrap_stream: %0d beats differ, got %0d beats want %0d", mis, got.size(), exp.size());
        end
        n_vec++;
        if (got.size() <= 255 * (PL + 1) || got[255 * (PL + 1)] !== 9'h0ff) begin
            n_err++; $display("FAIL wrap_header255: got %h want 0ff",
                              (got.size() > 255 * (PL + 1)) ? got[255 * (PL + 1)] : 9'h1ff);
        end
        n_vec++;
        if (got.size() <= 256 * (PL + 1) || got[256 * (PL + 1)] !== 9'h000) begin
            n_err++; $display("FAIL wrap_header256: got %h want 000",
                              (got.size() > 256 * (PL + 1)) ? got[256 * (PL + 1)] : 9'h1ff);
        end
        n_vec++; if (pkt_count !== 16'd257) begin n_err++; $display("FAIL wrap_pkt_count: got %0d want 257", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_starvation();
        test_uflow_reset();
        test_seq_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
